// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write sequencer sharing one enabled register bank among NREQ requesters.
// Optional readback comparator enabled by defining READBACK_CHECK_EN.
module dff_bank_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    E,
  output logic [WIDTH-1:0]        D,
  input  logic [WIDTH-1:0]        Q,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [PW-1:0]    rr_ptr_reg;
  logic [PW-1:0]    winner_reg;
  logic [WIDTH-1:0] data_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic [NREQ-1:0]  done_reg;
  logic             e_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]  winner_dec_next;
  logic [PW-1:0]    winner_next;
  logic             found_next;
  logic [SW-1:0]    scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign wdata_arr[gi]       = wdata[gi*WIDTH +: WIDTH];
      assign winner_dec_next[gi] = (winner_next == PW'(gi));
    end
  endgenerate

  // Scan from rr_ptr upward with wrap; the first set request bit wins.
  always_comb begin
    found_next  = 1'b0;
    winner_next = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + SW'(k);
      if (scan_idx >= SW'(NREQ)) begin
        scan_idx = scan_idx - SW'(NREQ);
      end
      if (!found_next && req[scan_idx[PW-1:0]]) begin
        found_next  = 1'b1;
        winner_next = scan_idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      winner_reg <= '0;
      data_reg   <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      e_reg      <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found_next) begin
            winner_reg <= winner_next;
            data_reg   <= wdata_arr[winner_next];
            gnt_reg    <= winner_dec_next;
            e_reg      <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          e_reg      <= 1'b0;
          done_reg   <= gnt_reg;
          rr_ptr_reg <= (winner_reg == PW'(NREQ - 1)) ? '0 : winner_reg + 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          done_reg  <= '0;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign E    = e_reg;
  assign D    = data_reg;
  assign busy = busy_reg;

`ifdef READBACK_CHECK_EN
  logic err_reg;

  // The bank has captured by DONE, so Q must match the latched data there.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == DONE && Q != data_reg) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_q;
  assign unused_q = ^Q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Bench for dff_bank_write_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model and a behavioural register bank.
module tb_dff_bank_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef READBACK_CHECK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  E;
  logic [WIDTH-1:0]      D;
  logic [WIDTH-1:0]      Q;
  logic                  busy;
  logic                  err;

  logic [WIDTH-1:0]      q_bank = '0;
  logic                  force_q_zero = 1'b0;

  int check_cnt = 0;
  int error_cnt = 0;

  always #5 clk = ~clk;

  dff_bank_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .Clock(clk), .Reset(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
    .E(E), .D(D), .Q(Q), .busy(busy), .err(err)
  );

  // Register bank: a row of enabled flip-flops with a common enable.
  always @(posedge clk) if (E) q_bank <= D;
  assign Q = force_q_zero ? '0 : q_bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transaction-level reference: phase 0 = waiting, 1 = bank being written, 2 = completion.
  int               m_phase = 0;
  int               m_win   = 0;
  int               m_ptr   = 0;
  logic [WIDTH-1:0] m_data  = '0;
  bit               m_err   = 1'b0;

  always @(posedge clk) begin : model
    bit found;
    int idx;
    if (!rst_n) begin
      m_phase = 0; m_win = 0; m_ptr = 0; m_data = '0; m_err = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (!found && req[idx]) begin
              found  = 1'b1;
              m_win  = idx;
              m_data = wdata[idx*WIDTH +: WIDTH];
            end
          end
          if (found) m_phase = 1;
        end
        1: begin
          m_ptr   = (m_win + 1) % NREQ;
          m_phase = 2;
        end
        default: begin
          if (RB_EN && Q != m_data) m_err = 1'b1;
          m_phase = 0;
        end
      endcase
    end
  end

  logic e_prev = 1'b0;

  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = (m_phase != 0) ? NREQ'(1 << m_win) : '0;
    check("gnt", gnt, exp_gnt);
    check("done", done, (m_phase == 2) ? exp_gnt : '0);
    check("e", E, m_phase == 1);
    check("d", D, m_data);
    check("busy", busy, m_phase != 0);
    check("err", err, m_err);
    check("e_twice", e_prev & E, 1'b0);
    check("gnt_onehot", $countones(gnt) <= 1, 1'b1);
    if (m_phase == 2) begin
      check("readback", q_bank, m_data);
      $display("txn: requester %0d data %02h", m_win, m_data);
    end
    e_prev = E;
  end

  int               done_idx[$];
  int               done_cyc[$];
  logic [WIDTH-1:0] e_data[$];

  initial begin
    rst_n = 1'b0;
    req   = '1;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (2) begin
      cyc(1);
      check("rst_gnt", gnt, '0);
      check("rst_busy", busy, 1'b0);
    end

    // Fairness with all requests held.
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cyc(1);
      if (c == 0) check("first_gnt", gnt, 4'b0001);
      if (done != 0) begin
        done_idx.push_back($clog2(done));
        done_cyc.push_back(c);
      end
      if (E) e_data.push_back(D);
      if (c == 14) req = '0;
    end
    check("fair_count", done_idx.size(), 5);
    for (int k = 0; k < done_idx.size() && k < 5; k++) begin
      check("fair_order", done_idx[k], k % NREQ);
      check("fair_spacing", done_cyc[k], 3 * k + 1);
    end
    for (int k = 0; k < e_data.size() && k < 5; k++) begin
      check("fair_data", e_data[k], 8'h11 * ((k % NREQ) + 1));
    end

    // Single request from requester 2.
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    cyc(1);
    check("single_e", E, 1'b1);
    check("single_d", D, 8'hA5);
    check("single_busy_w", busy, 1'b1);
    cyc(1);
    check("single_done", done, 4'b0100);
    check("single_q", Q, 8'hA5);
    check("single_busy_d", busy, 1'b1);
    req = '0;
    cyc(1);
    check("single_idle", busy, 1'b0);

    // Wrap: pointer now at 3.
    req = 4'b1001;
    cyc(1);
    check("wrap_1", gnt, 4'b1000);
    cyc(3);
    check("wrap_2", gnt, 4'b0001);
    cyc(3);
    check("wrap_3", gnt, 4'b1000);
    req = '0;
    cyc(2);

    // Request dropped and data changed during WRITE.
    wdata[1*WIDTH +: WIDTH] = 8'h5A;
    req = 4'b0010;
    cyc(1);
    req = '0;
    wdata[1*WIDTH +: WIDTH] = 8'hC3;
    check("abort_d", D, 8'h5A);
    cyc(1);
    check("abort_done", done, 4'b0010);
    check("abort_q", Q, 8'h5A);
    cyc(1);

    // Reset while in WRITE.
    req = 4'b0001;
    cyc(1);
    check("rstw_e_before", E, 1'b1);
    rst_n = 1'b0;
    cyc(1);
    check("rstw_e", E, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_done", done, '0);
    rst_n = 1'b1;
    req = '0;
    cyc(1);
    check("rstw_no_done", done, '0);

    // Readback fault: Q forced low during DONE of an FF write.
    wdata[2*WIDTH +: WIDTH] = 8'hFF;
    req = 4'b0100;
    cyc(2);
    force_q_zero = 1'b1;
    req = '0;
    cyc(1);
    force_q_zero = 1'b0;
    check("rb_err_set", err, RB_EN);
    wdata[0 +: WIDTH] = 8'h77;
    req = 4'b0001;
    cyc(1);
    req = '0;
    cyc(3);
    check("rb_err_sticky", err, RB_EN);
    rst_n = 1'b0;
    cyc(1);
    check("rb_err_clear", err, 1'b0);
    rst_n = 1'b1;

    // Random traffic, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ($urandom_range(0, 1) == 0) wdata = {$urandom};
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule

// File: doc/dff_bank_write_arbiter.md
Name: dff_bank_write_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one WIDTH-bit enabled register bank (a row of d_flip_flop cells with common E) among NREQ requesters.
- Serialises write requests and drives the bank's E/D pins.
- Returns a per-requester done pulse once the write has been captured.
- Sits between requester logic and the shared register bank; the bank's Q feeds back for observation and the optional readback check.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register bank data width.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset (sampled on rising Clock; 0 = reset).
- req  input  NREQ  per-requester write request; bit i is requester i.
- wdata  input  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; high from WRITE through DONE of the granted requester.
- done  output  NREQ  one-hot, one-cycle pulse in the DONE state for the granted requester.
- E  output  1  enable to the register bank; high only in the WRITE state.
- D  output  WIDTH  data to the register bank; holds the latched grant data while in WRITE.
- Q  input  WIDTH  register bank output, used for readback.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  readback mismatch flag; sticky until reset. Only present with READBACK_CHECK_EN; otherwise tied 0.

Behaviour:
- Reset: applies on any rising edge where Reset=0, regardless of state.
  - state=IDLE, gnt=0, done=0, E=0, D=0, busy=0, err=0, rr_ptr=0.
  - Reset mid-WRITE: E is 0 from the next cycle. The bank is not guaranteed written. No done pulse.
- FSM states: IDLE -> WRITE -> DONE -> IDLE. Exactly 3 cycles per transaction, no back-to-back overlap.
- IDLE:
  - If any req bit is set, select the winner by round-robin. Scan starts at rr_ptr, wraps modulo NREQ, and the first set bit wins.
  - On that edge: latch winner index and wdata slice into an internal data register, set gnt[winner], go to WRITE.
  - If req=0, stay in IDLE with all outputs 0.
- WRITE:
  - E=1 and D=latched data for exactly one cycle; the bank captures on the closing edge.
  - rr_ptr <= (winner+1) mod NREQ.
  - Go to DONE.
- DONE:
  - done[winner]=1 for one cycle, gnt still held.
  - Q now equals the written data. Go to IDLE; gnt clears on exit.
- Latency: from req sampled high in IDLE to done pulse is 2 cycles after the grant edge. E is high on the cycle after the grant edge.
- Handshake:
  - Requester holds req and wdata until it sees done.
  - wdata changes after the grant edge are ignored, because data is latched.
  - A req dropped during WRITE/DONE does not abort; the write completes and done still pulses.
  - A requester re-asserting req in the cycle after done competes normally at the next IDLE evaluation.
- Fairness:
  - With all req bits held high, grants rotate 0,1,2,...,NREQ-1,0.
  - The maximum wait for a held request is (NREQ-1) transactions.
- Wrap: rr_ptr increments modulo NREQ; winner NREQ-1 sets rr_ptr=0.
- Simultaneous events: Reset=0 overrides everything. New req bits arriving in WRITE/DONE are only evaluated on return to IDLE.
- E is never high in two consecutive cycles. gnt is never multi-hot.

Optional Feature:
- Macro: READBACK_CHECK_EN.
- Defined: in DONE, compare Q against the latched data.
  - On mismatch, set err=1 on the DONE exit edge.
  - err stays 1 until Reset=0. The done pulse is issued regardless.
- Undefined: no comparator; err is driven constant 0; Q is unused.

Test Plan:
- Reset=0 for 2 cycles while req=4'b1111 -> gnt=0, E=0, done=0, busy=0 throughout. First grant after release goes to requester 0.
- Single request: req=4'b0100, wdata[2]=8'hA5 -> E=1 with D=8'hA5 one cycle after the grant edge. done=4'b0100 on the next cycle. Q=8'hA5. busy high for 2 cycles.
- Fairness: req=4'b1111 held, distinct data 8'h11/22/33/44 -> done order 0,1,2,3,0. Transactions are spaced 3 cycles apart. E is never high two cycles running.
- Wrap: with rr_ptr=3 (after granting 2), set req=4'b1001 -> requester 3 wins, then requester 0, then 3.
- Abort tolerance: req[1] dropped and wdata[1] changed during WRITE -> D keeps the latched value 8'h5A and done[1] still pulses. Reset=0 asserted in WRITE -> IDLE next edge, no done.
- READBACK_CHECK_EN: force Q=8'h00 during DONE of an 8'hFF write -> err=1 next cycle, stays 1 across later good writes, clears only on Reset=0.
